// File: rtl/cram_loader.sv
// ---------------------------------------------------------------------------
// cram_loader
//   Configuration sequencer for a serial chain of NUM_LE logic elements.
//   Host bitstream words arrive over a valid/ready handshake. Each word is
//   serialized MSB first onto config_data_in, qualified by config_en.
//   After the last of NUM_LE*CFG_BITS bits has been shifted, the fabric is
//   held in reset for RST_CYCLES cycles. It is then released and enabled, and
//   done pulses for one cycle.
//
//   Ports
//     clk             clock, shared with the LE config chain
//     rst             synchronous active-high reset
//     start           begin a load (only looked at in IDLE)
//     abort           cancel an in-progress load
//     word_valid      host word available
//     word_data       host word, MSB shifted first
//     word_ready      loader takes the word this cycle
//     config_en       registered shift enable to the chain
//     config_data_in  registered serial config bit
//     le_nrst         fabric reset, active low
//     le_en           fabric enable
//     busy            high in every state except IDLE
//     done            one-cycle pulse when the fabric is released
//     configured      high after a successful load
// ---------------------------------------------------------------------------
module cram_loader #(
  parameter int NUM_LE     = 4,
  parameter int CFG_BITS   = 20,
  parameter int WORD_W     = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_en,
  output logic              config_data_in,
  output logic              le_nrst,
  output logic              le_en,
  output logic              busy,
  output logic              done,
  output logic              configured
);

  localparam int TOTAL = NUM_LE * CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int RW    = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, RELEASE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bits_done;   // bits shifted so far in this load
  logic [CW-1:0]     word_cnt;    // bits still to shift from the current word
  logic [RW-1:0]     rst_cnt;     // reset-hold cycles spent in RELEASE
  logic [CW-1:0]     bits_left;
  logic [CW-1:0]     word_len;

  // Only the last word can be short: clamp its length to what is left,
  // so the unused low bits of that word are never shifted.
  assign bits_left = CW'(TOTAL) - bits_done;
  assign word_len  = (int'(bits_left) > WORD_W) ? CW'(WORD_W) : bits_left;

  // Gating with abort keeps the host from seeing a handshake on a word
  // that the loader is about to drop.
  assign word_ready = (state == FETCH) && !abort;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      bits_done      <= '0;
      word_cnt       <= '0;
      rst_cnt        <= '0;
      config_en      <= 1'b0;
      config_data_in <= 1'b0;
      le_nrst        <= 1'b0;
      le_en          <= 1'b0;
      done           <= 1'b0;
      configured     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        // Partially shifted chain is left as is; the fabric stays in reset.
        state          <= IDLE;
        config_en      <= 1'b0;
        config_data_in <= 1'b0;
        le_nrst        <= 1'b0;
        le_en          <= 1'b0;
        configured     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= FETCH;
              le_nrst    <= 1'b0;
              le_en      <= 1'b0;
              configured <= 1'b0;
              bits_done  <= '0;
              word_cnt   <= '0;
              rst_cnt    <= '0;
            end
          end

          FETCH: begin
            config_en      <= 1'b0;
            config_data_in <= 1'b0;
            if (word_valid) begin
              shreg    <= word_data;
              word_cnt <= word_len;
              state    <= SHIFT;
            end
          end

          SHIFT: begin
            config_en      <= 1'b1;
            config_data_in <= shreg[WORD_W-1];
            shreg          <= {shreg[WORD_W-2:0], 1'b0};
            bits_done      <= bits_done + 1'b1;
            word_cnt       <= word_cnt - 1'b1;
            if (bits_done == CW'(TOTAL - 1)) begin
              state   <= RELEASE;
              rst_cnt <= '0;
            end else if (word_cnt == CW'(1)) begin
              state <= FETCH;
            end
          end

          RELEASE: begin
            // RST_CYCLES cycles of quiet chain with le_nrst low, then one
            // cycle that releases the fabric.
            config_en      <= 1'b0;
            config_data_in <= 1'b0;
            if (rst_cnt == RW'(RST_CYCLES)) begin
              le_nrst    <= 1'b1;
              le_en      <= 1'b1;
              done       <= 1'b1;
              configured <= 1'b1;
              state      <= IDLE;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cram_loader.md
Name: cram_loader

Overview:
- Configuration sequencer for a serial chain of NUM_LE logic elements (LEs). Each LE holds CFG_BITS of CRAM: 16 LUT bits plus 4 mode bits (reset_edge, reset_val, edge_mode, reg_mode), loaded MSB first.
- Accepts bitstream words from a host over a valid/ready handshake and serializes them onto config_data_in / config_en.
- After the last bit, holds the fabric in reset for RST_CYCLES cycles, then releases and enables the fabric.
- Sits between the top-level bitstream port and the LE chain's config_data_in / config_en / le_nrst / le_en pins.

Parameters:
- NUM_LE, 4: number of LEs in the config chain.
- CFG_BITS, 20: config bits per LE (16 LUT + 4 mode).
- WORD_W, 8: host bitstream word width.
- RST_CYCLES, 4: cycles le_nrst is held low after load; legal range >= 1.

Ports:
- clk  in  1  single clock; also clocks the LE config chain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel an in-progress load.
- word_valid  in  1  host word available.
- word_data  in  WORD_W  bitstream word; MSB shifted first.
- word_ready  out  1  loader accepts word this cycle.
- config_en  out  1  registered shift enable to LE chain.
- config_data_in  out  1  registered serial config bit.
- le_nrst  out  1  fabric reset, active-low.
- le_en  out  1  fabric enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when fabric is released.
- configured  out  1  high after a successful load; cleared by start, abort or rst.

Behaviour:
- Derived constants: TOTAL = NUM_LE*CFG_BITS; NWORDS = ceil(TOTAL/WORD_W).
- Stream order: the first bit shifted is the MSB of the first word, which lands in the far end of the chain. Exactly TOTAL bits are shifted. Unused low bits of the final word are discarded.
- rst (overrides all inputs): state=IDLE; word_ready=0, config_en=0, config_data_in=0, le_nrst=0, le_en=0, busy=0, done=0, configured=0; all counters=0.
- States: IDLE, FETCH, SHIFT, RELEASE.
- IDLE:
  - Outputs hold; le_nrst/le_en stay at their last values (0/0 out of reset, 1/1 after a successful load).
  - start=1 -> FETCH next cycle. On that edge: le_nrst<=0, le_en<=0, configured<=0, bit counter<=0.
- FETCH:
  - word_ready=1 (combinational from state); config_en=0.
  - On word_valid&word_ready: load the shift register, set the per-word bit count to min(WORD_W, TOTAL - bits_done), -> SHIFT.
  - word_valid low: wait indefinitely.
- SHIFT:
  - Each cycle: config_en<=1 and config_data_in<=shreg MSB. Shift the register left; increment bits_done; decrement the word count.
  - Exactly one bit per cycle; word_ready=0.
  - Word count reaches 0 with bits_done<TOTAL -> FETCH. config_en drops to 0 in the following cycle (bubbles are legal; the LE shifts only when config_en=1).
  - bits_done reaches TOTAL -> RELEASE.
  - Latency: bit k of a word appears on config_data_in k+1 cycles after the accepting handshake.
- RELEASE:
  - config_en=0, config_data_in=0, le_nrst=0 for RST_CYCLES cycles.
  - Then, in one cycle: le_nrst<=1, le_en<=1, done<=1 (single cycle), configured<=1, -> IDLE.
- abort=1 in FETCH/SHIFT/RELEASE:
  - Next cycle: IDLE, config_en=0, config_data_in=0, word_ready=0, le_nrst=0, le_en=0, configured=0, no done pulse.
  - A partially shifted chain is left as is; the fabric stays in reset.
- Priority: abort in IDLE is ignored. start while busy is ignored. abort beats a simultaneous handshake; that word is not consumed.
- Counters sized $clog2(TOTAL+1); no wrap is possible since the bit counter stops at TOTAL.

Test Plan (NUM_LE=2, CFG_BITS=20, WORD_W=8, RST_CYCLES=4 -> TOTAL=40, NWORDS=5):
- Reset then idle:
  - Hold rst 2 cycles.
  - All outputs 0, busy=0.
  - word_ready stays 0 with word_valid=1 and no start.
- Full load, back-to-back words:
  - start, then words 0xA5,0x3C,0xFF,0x00,0x96 with valid always high.
  - Captured config_data_in where config_en=1 equals exactly those 40 bits, MSB first.
  - Each word produces 8 config_en cycles followed by 1 bubble.
  - le_nrst low for exactly 4 cycles after the last bit.
  - done pulses once, with le_nrst=1, le_en=1, configured=1 in that same cycle.
- Host stalls:
  - Drop word_valid for 7 cycles before word 3.
  - config_en stays 0 during the stall; captured bitstream is identical to the previous scenario.
- Partial last word:
  - CFG_BITS=20, NUM_LE=1 -> TOTAL=20, 3 words; last word 0xF0.
  - Only 4 bits (1,1,1,1) shifted from the last word; total config_en-high cycles = 20.
- Abort mid-SHIFT:
  - Assert abort after 13 bits.
  - Next cycle: busy=0, config_en=0, le_nrst=0, le_en=0, configured=0, no done.
  - A subsequent start/full load completes normally.
- End-to-end with chained LE models:
  - Load a per-LE config of {4'b0010, xor LUT}.
  - After done, sweep the LE select inputs 0..15; each LE output equals the parity of the select value.
  - start asserted during SHIFT has no effect.
